bin_to_bcd_seq: RTL

//  Sequential shift-add-3 (double-dabble) binary-to-BCD converter.
//  - Sits directly upstream of the per-digit hex-to-7-segment decoders.
//  - Each 4-bit slice of oBCD drives one decoder's digit input, so a binary

---
 rtl/bin_to_bcd_seq_if.sv | 23 ++
 rtl/bin_to_bcd_seq.sv | 109 ++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq_if.sv
// Start/done handshake bundle for the sequential binary-to-BCD converter.
// The master issues starts and binary values; the slave returns BCD results.
interface bin_to_bcd_seq_if #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
);
    logic                  iSTART;
    logic [BIN_W-1:0]      iBIN;
    logic                  oBUSY;
    logic                  oDONE;
    logic [4*DIGITS-1:0]   oBCD;
    logic                  oOVF;

    modport master (
        output iSTART, iBIN,
        input  oBUSY, oDONE, oBCD, oOVF
    );

    modport slave (
        input  iSTART, iBIN,
        output oBUSY, oDONE, oBCD, oOVF
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 (double-dabble) binary-to-BCD converter.
// Converts one bit per clock; results only move to the outputs on done.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic            iCLK,
    input  logic            iRST_N,
    bin_to_bcd_seq_if.slave bus
);
    localparam int CW = $clog2(BIN_W + 1);
    localparam int BW = 4 * DIGITS;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t               state_q, state_d;
    logic [BIN_W-1:0]     bin_q, bin_d;
    logic [BW-1:0]        bcd_q, bcd_d;
    logic                 ovf_q, ovf_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [BW-1:0]        obcd_q, obcd_d;
    logic                 oovf_q, oovf_d;

    logic [BW-1:0]        adj;
    logic                 ovf_new;
    logic [BW+BIN_W-1:0]  shifted;

    // Add-3 correction: any digit of 5..9 becomes 8..12 so the shift carries.
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        ovf_new = ovf_q | adj[BW-1];
        shifted = {adj, bin_q} << 1;
    end

    // Next-state and output logic for the IDLE/SHIFT controller.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        obcd_d  = obcd_q;
        oovf_d  = oovf_q;
        unique case (state_q)
            IDLE: begin
                if (bus.iSTART) begin
                    bin_d   = bus.iBIN;
                    bcd_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = CW'(BIN_W);
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                {bcd_d, bin_d} = shifted;
                ovf_d = ovf_new;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    obcd_d  = ovf_new ? {DIGITS{4'h9}} : shifted[BW+BIN_W-1:BIN_W];
                    oovf_d  = ovf_new;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any conversion in flight.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            obcd_q  <= '0;
            oovf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            obcd_q  <= obcd_d;
            oovf_q  <= oovf_d;
        end
    end

    assign bus.oBUSY = busy_q;
    assign bus.oDONE = done_q;
    assign bus.oBCD  = obcd_q;
    assign bus.oOVF  = oovf_q;
endmodule
